// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared coin codes, output FSM states and event-priority helpers
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_2    = 2'b10,
        COIN_5    = 2'b11
    } coin_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        GAP  = 2'b10
    } out_state_e;

    // Event vector order is {coin5, coin2, coin1}; the highest value wins.
    function automatic coin_code_e coin_prio(input logic [2:0] ev);
        coin_code_e code;
        if (ev[2])      code = COIN_5;
        else if (ev[1]) code = COIN_2;
        else if (ev[0]) code = COIN_1;
        else            code = COIN_NONE;
        return code;
    endfunction

    function automatic logic coin_multi(input logic [2:0] ev);
        return (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - per-sensor 2-flop sync, optional debounce (COIN_ACCEPTOR_DEBOUNCE_EN), rising-edge event
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic event_o
);

    logic [1:0] sync_q;
    logic [1:0] prime_q;
    logic       filt;
    logic       filt_prev_q;
    logic       armed_q;

`ifdef COIN_ACCEPTOR_DEBOUNCE_EN
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) filt_d = sync_q[1];
            else                                  cnt_d  = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    localparam int deb_unused = DEBOUNCE_CYCLES;
    assign filt = sync_q[1];
`endif

    // A sensor is armed only after a genuine low is seen once the synchronizer
    // holds real samples, so a coin held across reset release never fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            prime_q     <= '0;
            filt_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw_i};
            prime_q     <= {prime_q[0], 1'b1};
            filt_prev_q <= filt;
            armed_q     <= armed_q | (prime_q[1] & ~filt & ~sync_q[1]) | (filt_prev_q & ~filt);
        end
    end

    assign event_o = filt & ~filt_prev_q & armed_q;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin acceptor top: sensor filtering, code FIFO, IDLE/EMIT/GAP output FSM; debounce via COIN_ACCEPTOR_DEBOUNCE_EN
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    input  logic       coin5_raw,
    input  logic       vend_ready,
    output logic [1:0] coin_in,
    output logic       coin_reject,
    output logic [3:0] fifo_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [2:0] raw_w;
    logic [2:0] ev;

    assign raw_w = {coin5_raw, coin2_raw, coin1_raw};

    for (genvar i = 0; i < 3; i++) begin : g_sensor
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_w[i]),
            .event_o(ev[i])
        );
    end

    coin_code_e          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [3:0]          count_q, count_d;
    logic                reject_q;
    out_state_e          state_q;
    coin_code_e          coin_in_q;
    coin_code_e          push_code;
    logic                pop, push;

    assign push_code = coin_prio(ev);
    assign pop       = (state_q == IDLE) && (count_q != 4'd0) && vend_ready;
    // A full FIFO still accepts when the same cycle frees a slot.
    assign push      = (|ev) && ((count_q < 4'(FIFO_DEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            reject_q <= ((|ev) && !push) || coin_multi(ev);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            coin_in_q <= COIN_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        coin_in_q <= fifo_mem[rd_ptr_q];
                        state_q   <= EMIT;
                    end else begin
                        coin_in_q <= COIN_NONE;
                    end
                end
                EMIT: begin
                    coin_in_q <= COIN_NONE;
                    state_q   <= GAP;
                end
                GAP: begin
                    coin_in_q <= COIN_NONE;
                    state_q   <= IDLE;
                end
                default: begin
                    coin_in_q <= COIN_NONE;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign coin_in     = coin_in_q;
    assign coin_reject = reject_q;
    assign fifo_count  = count_q;

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles needed to change a filtered sensor level (range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, coin-code buffer entries (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports coin1_raw, coin2_raw, coin5_raw  input  1 each  asynchronous coin-sensor levels, high while a coin passes.
REQ-006 SHALL have port vend_ready  input  1  downstream vending controller can take a coin code.
REQ-007 SHALL have port coin_in  output  2  registered code to downstream: 00 none, 01 one-unit, 10 two-unit, 11 five-unit.
REQ-008 SHALL have port coin_reject  output  1  registered one-cycle pulse: a detected coin was not buffered (route to return chute).
REQ-009 SHALL have port fifo_count  output  4  registered number of buffered codes, 0..FIFO_DEPTH.

Function
REQ-010 SHALL pass each raw sensor through a 2-flop synchronizer before any other logic.
REQ-011 SHALL change a filtered level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match restarts the count.
REQ-012 SHALL raise a coin event in cycle E, when a filtered level is high and was low in E-1.
REQ-013 SHALL push, at the end of E, the event's code when fifo_count < FIFO_DEPTH, or when fifo_count == FIFO_DEPTH and a pop occurs in E.
REQ-014 SHALL, when the push is refused, assert coin_reject in E+1 and leave the FIFO unchanged.
REQ-015 SHALL, for simultaneous events in one cycle, push only the highest value (5 > 2 > 1) and pulse coin_reject once in E+1 for the dropped coins.
REQ-016 SHALL use an output FSM with states IDLE, EMIT and GAP; reset state is IDLE.
REQ-017 SHALL, in IDLE with fifo_count > 0 and vend_ready == 1, pop the head entry, load coin_in and enter EMIT.
REQ-018 SHALL hold the code on coin_in for exactly the one cycle spent in EMIT, then go to GAP with coin_in = 00.
REQ-019 SHALL spend exactly one cycle in GAP, then return to IDLE.
REQ-020 SHALL therefore separate nonzero codes by at least one 00 cycle; with vend_ready held high, peak rate is one code per 3 cycles.
REQ-021 SHALL drive coin_in = 00 in every IDLE and GAP cycle.
REQ-022 SHALL deliver codes in arrival (FIFO) order; best-case latency from event E to nonzero coin_in is E+2.
REQ-023 SHALL ignore vend_ready outside IDLE; a vend_ready drop after the pop does not cancel EMIT.

Reset
REQ-024 SHALL, while reset is low, force coin_in = 00, coin_reject = 0, fifo_count = 0, FSM = IDLE, all synchronizer, filtered and counter flops = 0, and FIFO pointers = 0.
REQ-025 SHALL discard buffered codes on reset asserted mid-operation; none are emitted after release.
REQ-026 SHALL raise no event for a sensor held high across reset release until it has been filtered low, then filtered high again.

Configuration
REQ-027 SHALL compile debouncing in only when macro COIN_ACCEPTOR_DEBOUNCE_EN is defined.
REQ-028 SHALL, without COIN_ACCEPTOR_DEBOUNCE_EN, use the synchronized level directly as the filtered level, ignore DEBOUNCE_CYCLES, and keep all other behaviour unchanged.

Structure
REQ-029 SHALL take from shared package coin_pkg the codes COIN_NONE/COIN_1/COIN_2/COIN_5 (00/01/10/11) and the output-FSM state enum.
REQ-030 SHALL implement synchronizer, debounce and rising-edge detect in sub-module coin_debounce, instantiated once per sensor.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, debounce enabled)
REQ-031 SHALL cover: coin2_raw high 10 cycles, vend_ready=1 -> exactly one coin_in=10 pulse, one cycle wide, no coin_reject.
REQ-032 SHALL cover: coin1_raw glitch high 3 cycles -> no event; coin_in stays 00, fifo_count stays 0.
REQ-033 SHALL cover: vend_ready=0, six separate coin1 inserts -> fifo_count reaches 4, two coin_reject pulses; after vend_ready=1, four 01 codes each followed by a 00 cycle.
REQ-034 SHALL cover: coin1_raw and coin5_raw rising in the same cycle -> one coin_in=11 pulse and one coin_reject pulse.
REQ-035 SHALL cover: 3 codes buffered, reset pulsed low for 1 cycle -> all outputs 0 immediately, no codes emitted afterwards.
REQ-036 SHALL cover: coin5_raw held high through reset release -> no code until low 4+ cycles then high 4+ cycles, then a single 11 pulse.
